// File: rtl/bc_clr_en_pipe_reg_if.sv
// Valid/ready handshake bundle for bc_clr_en_pipe_reg: upstream (iVld/oRdy/iDat) and
// downstream (oVld/iRdy/oDat) sides, named from the pipeline's point of view.
interface bc_clr_en_pipe_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;

    // Pipeline side.
    modport slave (
        input  iVld, iDat, iRdy,
        output oRdy, oVld, oDat
    );

    // Environment side: drives upstream data and downstream ready.
    modport master (
        output iVld, iDat, iRdy,
        input  oRdy, oVld, oDat
    );
endinterface

// File: rtl/bc_clr_en_pipe_reg.sv
// DEPTH-stage elastic clear/enable register pipeline with valid/ready backpressure.
// Define BC_CLR_EN_PIPE_CNT_EN to add the registered occupancy output oCnt.
module bc_clr_en_pipe_reg #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 3,
    parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1),
    localparam int unsigned     CntW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iClr,
`ifdef BC_CLR_EN_PIPE_CNT_EN
    output logic [CntW-1:0]       oCnt,
`endif
    bc_clr_en_pipe_reg_if.slave   bus
);

    if (DEPTH == 0) begin : g_bad_depth
        $fatal(1, "bc_clr_en_pipe_reg: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             flush;

    // Reset and clear share one synchronous flush path; reset is simply folded in here.
    assign flush = !rst || iClr;

    always_comb begin
        rdy[DEPTH] = bus.iRdy;
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            rdy[s] = !vld_q[s] || rdy[s+1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = '0;
            for (int s = 0; s < int'(DEPTH); s++) begin
                dat_d[s] = INI_DATA;
            end
        end else begin
            if (rdy[0]) begin
                vld_d[0] = bus.iVld;
                if (bus.iVld) dat_d[0] = bus.iDat;
            end
            // Bubbles advance the valid bit only; data registers keep their last beat.
            for (int s = 1; s < int'(DEPTH); s++) begin
                if (rdy[s]) begin
                    vld_d[s] = vld_q[s-1];
                    if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        vld_q <= vld_d;
        dat_q <= dat_d;
    end

    assign bus.oRdy = rdy[0] && !iClr;
    assign bus.oVld = vld_q[DEPTH-1];
    assign bus.oDat = dat_q[DEPTH-1];

`ifdef BC_CLR_EN_PIPE_CNT_EN
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            in_fire, out_fire;

    always_comb begin
        in_fire  = bus.iVld && bus.oRdy;
        out_fire = bus.oVld && bus.iRdy;
        cnt_d    = cnt_q + CntW'(in_fire) - CntW'(out_fire);
        if (flush) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign oCnt = cnt_q;
`endif

endmodule

// File: tb/tb_bc_clr_en_pipe_reg.sv
// Directed and randomized-bubble checks for bc_clr_en_pipe_reg (WIDTH=32, DEPTH=3, INI_DATA=1).
module tb_bc_clr_en_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    logic iClr;
`ifdef BC_CLR_EN_PIPE_CNT_EN
    logic [1:0] cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    bc_clr_en_pipe_reg_if #(.WIDTH(32)) bus ();

    bc_clr_en_pipe_reg #(
        .WIDTH   (32),
        .DEPTH   (3),
        .INI_DATA(32'h1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iClr(iClr),
`ifdef BC_CLR_EN_PIPE_CNT_EN
        .oCnt(cnt),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_dat;
    logic [31:0] prev_dat;
    logic        prev_stall;
    int          idx;
    int          rcv;

    initial begin
        rst      = 1'b0;
        iClr     = 1'b0;
        bus.iVld = 1'b0;
        bus.iDat = '0;
        bus.iRdy = 1'b0;

        // Reset
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_oVld", 32'(bus.oVld), 32'd0);
        check_eq("rst_oDat", bus.oDat, 32'h1);
        check_eq("rst_oRdy", 32'(bus.oRdy), 32'd1);
`ifdef BC_CLR_EN_PIPE_CNT_EN
        check_eq("rst_oCnt", 32'(cnt), 32'd0);
`endif

        // Streaming A0..A9 with iRdy held high
        for (int c = 0; c < 14; c++) begin
            bus.iRdy = 1'b1;
            bus.iVld = (c < 10);
            bus.iDat = 32'hA0 + 32'(c);
            #1;
            if (c < 10) check_eq("str_oRdy", 32'(bus.oRdy), 32'd1);
            if (c < 3) begin
                check_eq("str_lat_oVld", 32'(bus.oVld), 32'd0);
            end else if (c < 13) begin
                check_eq("str_oVld", 32'(bus.oVld), 32'd1);
                check_eq("str_oDat", bus.oDat, 32'hA0 + 32'(c - 3));
            end else begin
                check_eq("str_tail_oVld", 32'(bus.oVld), 32'd0);
            end
            tick();
        end

        // Backpressure: only three beats fit while iRdy is low
        bus.iRdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.iVld = 1'b1;
            bus.iDat = 32'hB0 + 32'(idx);
            #1;
            check_eq("bp_oRdy", 32'(bus.oRdy), (c < 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                check_eq("bp_oVld", 32'(bus.oVld), 32'd1);
                check_eq("bp_hold_oDat", bus.oDat, 32'hB0);
            end
            if (bus.oRdy) idx++;
            tick();
        end
        check_eq("bp_accepted", 32'(idx), 32'd3);
`ifdef BC_CLR_EN_PIPE_CNT_EN
        check_eq("bp_oCnt", 32'(cnt), 32'd3);
`endif
        bus.iRdy = 1'b1;
        rcv = 0;
        for (int c = 0; c < 30 && rcv < 5; c++) begin
            bus.iVld = (idx < 5);
            bus.iDat = 32'hB0 + 32'(idx);
            #1;
            if (c == 0) check_eq("bp_release_oRdy", 32'(bus.oRdy), 32'd1);
            if (bus.iVld && bus.oRdy) idx++;
            if (bus.oVld && bus.iRdy) begin
                check_eq("bp_oDat", bus.oDat, 32'hB0 + 32'(rcv));
                rcv++;
            end
            tick();
        end
        check_eq("bp_delivered", 32'(rcv), 32'd5);
        bus.iVld = 1'b0;
        #1;
        check_eq("bp_no_dup_oVld", 32'(bus.oVld), 32'd0);

        // Random bubbles on both sides
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int c = 0; c < 500; c++) begin
            bus.iVld = 1'($urandom_range(0, 1));
            bus.iRdy = 1'($urandom_range(0, 1));
            bus.iDat = $urandom;
            #1;
            if (prev_stall) begin
                check_eq("bub_stall_oVld", 32'(bus.oVld), 32'd1);
                check_eq("bub_stall_oDat", bus.oDat, prev_dat);
            end
`ifdef BC_CLR_EN_PIPE_CNT_EN
            check_eq("bub_oCnt", 32'(cnt), 32'(q.size()));
`endif
            if (bus.iVld && bus.oRdy) q.push_back(bus.iDat);
            if (bus.oVld && bus.iRdy) begin
                check_eq("bub_not_underflow", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_dat = q.pop_front();
                    check_eq("bub_oDat", bus.oDat, exp_dat);
                end
            end
            prev_stall = bus.oVld && !bus.iRdy;
            prev_dat   = bus.oDat;
            tick();
        end
        bus.iVld = 1'b0;
        bus.iRdy = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            #1;
            if (bus.oVld) begin
                exp_dat = q.pop_front();
                check_eq("bub_drain_oDat", bus.oDat, exp_dat);
            end
            tick();
        end
        check_eq("bub_drained", 32'(q.size()), 32'd0);
        #1;
        check_eq("bub_empty_oVld", 32'(bus.oVld), 32'd0);

        // Clear with two beats in flight
        tick();
        bus.iVld = 1'b1;
        bus.iDat = 32'hC0;
        tick();
        bus.iDat = 32'hC1;
        tick();
        iClr     = 1'b1;
        bus.iDat = 32'hCC;
        #1;
        check_eq("clr_oRdy", 32'(bus.oRdy), 32'd0);
        tick();
        iClr     = 1'b0;
        bus.iVld = 1'b0;
        #1;
        check_eq("clr_oVld", 32'(bus.oVld), 32'd0);
        check_eq("clr_oDat", bus.oDat, 32'h1);
`ifdef BC_CLR_EN_PIPE_CNT_EN
        check_eq("clr_oCnt", 32'(cnt), 32'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("clr_nothing_out", 32'(bus.oVld), 32'd0);
        end

        // Reset while full and stalled
        bus.iRdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.iVld = 1'b1;
            bus.iDat = 32'hD0 + 32'(c);
            #1;
            if (c == 3) check_eq("rs_full_oRdy", 32'(bus.oRdy), 32'd0);
            tick();
        end
        check_eq("rs_full_oVld", 32'(bus.oVld), 32'd1);
        check_eq("rs_full_oDat", bus.oDat, 32'hD0);
        rst = 1'b0;
        tick();
        bus.iVld = 1'b0;
        #1;
        check_eq("rs_oVld", 32'(bus.oVld), 32'd0);
        check_eq("rs_oDat", bus.oDat, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("rs_oRdy", 32'(bus.oRdy), 32'd1);
`ifdef BC_CLR_EN_PIPE_CNT_EN
        check_eq("rs_oCnt", 32'(cnt), 32'd0);
`endif
        tick();
        check_eq("rs_after_oVld", 32'(bus.oVld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
